// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter: default widths,
// requester slot assignments and the hardwired-zero register address.
package regfile_pkg;

   localparam int RF_XLEN       = 32;
   localparam int RF_ADDRESSLEN = 4;
   localparam int RF_NREQ       = 3;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_CSR  = 2;

   localparam logic [RF_ADDRESSLEN-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves to one past the winner whenever advance is asserted.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr;
   logic          found;
   int            idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters through a
// registered output stage. Define RF_WARB_FWD_EN to add the forwarding taps.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int XLEN       = RF_XLEN,
   parameter int ADDRESSLEN = RF_ADDRESSLEN,
   parameter int NREQ       = RF_NREQ
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*ADDRESSLEN-1:0] req_rd,
   input  logic [NREQ*XLEN-1:0]       req_data,
   output logic [NREQ-1:0]            req_ready,
   output logic                       wEn,
   output logic [ADDRESSLEN-1:0]      rd,
   output logic [XLEN-1:0]            data,
   output logic                       busy
`ifdef RF_WARB_FWD_EN
   ,
   input  logic [ADDRESSLEN-1:0]      fwd_rs1,
   input  logic [ADDRESSLEN-1:0]      fwd_rs2,
   output logic                       fwd1_hit,
   output logic                       fwd2_hit,
   output logic [XLEN-1:0]            fwd_data
`endif
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_live;
   logic [NREQ-1:0]       gnt;
   logic [IW-1:0]         gnt_idx;
   logic                  any_gnt;
   logic [ADDRESSLEN-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;

   // Masking requests in reset keeps ready and busy low without touching the arbiter.
   assign req_live = reset ? '0 : req_valid;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_live),
      .advance (any_gnt),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign any_gnt   = |gnt;
   assign req_ready = gnt;
   assign busy      = |(req_live & ~gnt);

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (int'(gnt_idx) == i) begin
            sel_rd   = req_rd[i*ADDRESSLEN +: ADDRESSLEN];
            sel_data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   // A grant to register 0 still consumes its turn but never raises the write enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         wEn  <= 1'b0;
         rd   <= '0;
         data <= '0;
      end else if (any_gnt) begin
         wEn  <= (sel_rd != ADDRESSLEN'(REG_ZERO));
         rd   <= sel_rd;
         data <= sel_data;
      end else begin
         wEn  <= 1'b0;
      end
   end

`ifdef RF_WARB_FWD_EN
   assign fwd1_hit = wEn && (rd == fwd_rs1) && (fwd_rs1 != ADDRESSLEN'(REG_ZERO));
   assign fwd2_hit = wEn && (rd == fwd_rs2) && (fwd_rs2 != ADDRESSLEN'(REG_ZERO));
   assign fwd_data = data;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a scoreboard predicts the output
// stage each cycle while scenario tasks check grants, busy and corner cases.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   localparam int NR = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid;
   logic [11:0] req_rd;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        wEn;
   logic [3:0]  rd;
   logic [31:0] data;
   logic        busy;
`ifdef RF_WARB_FWD_EN
   logic [3:0]  fwd_rs1, fwd_rs2;
   logic        fwd1_hit, fwd2_hit;
   logic [31:0] fwd_data;
`endif

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wEn       (wEn),
      .rd        (rd),
      .data      (data),
      .busy      (busy)
`ifdef RF_WARB_FWD_EN
      ,
      .fwd_rs1   (fwd_rs1),
      .fwd_rs2   (fwd_rs2),
      .fwd1_hit  (fwd1_hit),
      .fwd2_hit  (fwd2_hit),
      .fwd_data  (fwd_data)
`endif
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        wen;
      logic        known;
      logic [3:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          m_ptr   = 0;
   logic [3:0]  m_rd    = '0;
   logic [31:0] m_data  = '0;
   logic        m_known = 1'b0;

   // Scoreboard: compare the output stage with the prediction made one cycle
   // earlier, then predict what the coming posedge will load.
   always @(negedge clk) begin : scoreboard
      exp_t e;
      int   g;
      int   idx;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (wEn !== e.wen || (e.known && (rd !== e.rd || data !== e.data))) begin
            errors++;
            $display("FAIL sb_out @%0t: got wEn=%0b rd=%0d data=%h, want wEn=%0b rd=%0d data=%h",
                     $time, wEn, rd, data, e.wen, e.rd, e.data);
         end
      end
      if (reset) begin
         m_ptr = 0; m_rd = '0; m_data = '0; m_known = 1'b1;
         sb.push_back('{wen: 1'b0, known: 1'b1, rd: 4'd0, data: 32'd0});
      end else begin
         g = -1;
         for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
         end
         if (g >= 0) begin
            m_rd    = req_rd[g*4 +: 4];
            m_data  = req_data[g*32 +: 32];
            m_ptr   = (g + 1) % NR;
            m_known = (m_rd != 4'd0);
            sb.push_back('{wen: (m_rd != 4'd0), known: m_known, rd: m_rd, data: m_data});
         end else begin
            sb.push_back('{wen: 1'b0, known: m_known, rd: m_rd, data: m_data});
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic [3:0] r, input logic [31:0] d);
      req_valid[i]        = v;
      req_rd[i*4 +: 4]    = r;
      req_data[i*32 +: 32] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_req(0, 1'b1, 4'd1, 32'h0000_0011);
      set_req(1, 1'b1, 4'd2, 32'h0000_0022);
      set_req(2, 1'b1, 4'd3, 32'h0000_0033);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 3'b000 || busy !== 1'b0 || wEn !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b wEn=%b, want 000/0/0", req_ready, busy, wEn);
         end
         next_cycle();
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 3'b001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: ready=%b busy=%b, want 001/1", req_ready, busy);
      end
      next_cycle();
      req_valid = '0;
   endtask

   task automatic test_single_load();
      set_req(REQ_LOAD, 1'b1, 4'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (req_ready !== 3'b010 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load_grant: ready=%b busy=%b, want 010/0", req_ready, busy);
      end
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (wEn !== 1'b1 || rd !== 4'd5 || data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL load_write: wEn=%b rd=%0d data=%h, want 1/5/deadbeef", wEn, rd, data);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (wEn !== 1'b0) begin
         errors++;
         $display("FAIL load_idle: wEn=%b, want 0", wEn);
      end
      next_cycle();
   endtask

   task automatic test_round_robin();
      int          exp_seq[6] = '{0, 1, 2, 0, 1, 2};
      logic [2:0]  exp_r;
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4'(1 + i), 32'hA000_0000 + 32'(i));
      for (int k = 0; k < 6; k++) begin
         exp_r = 3'b001 << exp_seq[k];
         @(negedge clk);
         checks++;
         if (req_ready !== exp_r || busy !== 1'b1) begin
            errors++;
            $display("FAIL rr_turn%0d: ready=%b busy=%b, want %b/1", k, req_ready, busy, exp_r);
         end
         next_cycle();
         set_req(exp_seq[k], 1'b1, 4'(1 + ((k * 3 + exp_seq[k] + 4) % 15)),
                 32'hB000_0000 + 32'(k * 16 + exp_seq[k]));
      end
      req_valid = '0;
   endtask

   task automatic test_reg_zero();
      set_req(REQ_ALU, 1'b1, 4'd0, 32'h0000_1234);
      @(negedge clk);
      checks++;
      if (req_ready !== 3'b001) begin
         errors++;
         $display("FAIL rd0_grant: ready=%b, want 001", req_ready);
      end
      next_cycle();
      set_req(REQ_ALU,  1'b1, 4'd4, 32'h0000_4444);
      set_req(REQ_LOAD, 1'b1, 4'd6, 32'h0000_6666);
      @(negedge clk);
      checks++;
      if (wEn !== 1'b0 || req_ready !== 3'b010) begin
         errors++;
         $display("FAIL rd0_suppress: wEn=%b ready=%b, want 0/010", wEn, req_ready);
      end
      next_cycle();
      req_valid[REQ_LOAD] = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 3'b001) begin
         errors++;
         $display("FAIL rd0_followup: ready=%b, want 001", req_ready);
      end
      next_cycle();
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      set_req(REQ_LOAD, 1'b1, 4'd7, 32'hCAFE_0007);
      @(negedge clk);
      checks++;
      if (req_ready !== 3'b010) begin
         errors++;
         $display("FAIL mid_grant: ready=%b, want 010", req_ready);
      end
      next_cycle();
      reset     = 1'b1;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (wEn !== 1'b1 || rd !== 4'd7 || req_ready !== 3'b000) begin
         errors++;
         $display("FAIL mid_staged: wEn=%b rd=%0d ready=%b, want 1/7/000", wEn, rd, req_ready);
      end
      next_cycle();
      reset     = 1'b0;
      req_valid = 3'b111;
      @(negedge clk);
      checks++;
      if (wEn !== 1'b0 || rd !== 4'd0 || req_ready !== 3'b001) begin
         errors++;
         $display("FAIL mid_dropped: wEn=%b rd=%0d ready=%b, want 0/0/001", wEn, rd, req_ready);
      end
      next_cycle();
      req_valid = '0;
      next_cycle();
   endtask

   task automatic test_random();
      int         w[3] = '{0, 0, 0};
      int         worst;
      logic [2:0] acc;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         acc = req_ready;
         checks++;
         if (!$onehot0(acc) || (acc & ~req_valid) != 3'b000 || (req_valid != 3'b000 && acc == 3'b000)) begin
            errors++;
            $display("FAIL grant_legal: ready=%b valid=%b", acc, req_valid);
         end
         worst = 0;
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && !acc[i]) w[i]++;
            else w[i] = 0;
            if (w[i] > worst) worst = w[i];
         end
         checks++;
         if (worst >= NR) begin
            errors++;
            $display("FAIL starvation: waited %0d cycles, want < %0d", worst, NR);
         end
         next_cycle();
         for (int i = 0; i < NR; i++) begin
            if (acc[i] || !req_valid[i]) begin
               if ($urandom_range(0, 3) != 0)
                  set_req(i, 1'b1, 4'($urandom_range(0, 15)), $urandom);
               else
                  req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
      next_cycle();
      next_cycle();
   endtask

`ifdef RF_WARB_FWD_EN
   task automatic test_forward();
      fwd_rs1 = 4'd3;
      fwd_rs2 = 4'd0;
      set_req(REQ_ALU, 1'b1, 4'd3, 32'h3333_0003);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (fwd1_hit !== 1'b1 || fwd_data !== 32'h3333_0003 || fwd2_hit !== 1'b0) begin
         errors++;
         $display("FAIL fwd_hit: hit1=%b hit2=%b fwd_data=%h, want 1/0/33330003", fwd1_hit, fwd2_hit, fwd_data);
      end
      next_cycle();
      fwd_rs2 = 4'd3;
      @(negedge clk);
      checks++;
      if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
         errors++;
         $display("FAIL fwd_idle: hit1=%b hit2=%b, want 0/0", fwd1_hit, fwd2_hit);
      end
      next_cycle();
   endtask
`endif

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_rd    = '0;
      req_data  = '0;
`ifdef RF_WARB_FWD_EN
      fwd_rs1 = '0;
      fwd_rs2 = '0;
`endif
      test_reset();
      test_single_load();
      test_round_robin();
      test_reg_zero();
      test_reset_mid();
      test_random();
`ifdef RF_WARB_FWD_EN
      test_forward();
`endif
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
